// File: rtl/top_k_pkg.sv
// Constants shared by the top-k merger and dispatcher: message width and
// the bit positions of the header, payload and metadata fields.
package top_k_pkg;
    localparam int MSG_WIDTH   = 600;
    localparam int HDR_RST_BIT = 0;
    localparam int HDR_BLK_LSB = 2;
    localparam int HDR_BLK_MSB = 31;
    localparam int PAYLOAD_LSB = 32;
    localparam int META_LSB    = 512;
endpackage

// File: rtl/sync_fifo_lb.sv
// Register-based loopback FIFO. Reads are combinational from rd_ptr, so a
// word is visible one cycle after it is written. flush empties it like rst.
module sync_fifo_lb #(
    parameter int WIDTH = 600,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/omni_merger.sv
// Merges the network RX stream with recirculated dispatcher loopback words into
// one registered stream, bounding loopback starvation and discarding reset headers.
module omni_merger
    import top_k_pkg::*;
#(
    parameter int WIDTH         = MSG_WIDTH,
    parameter int LB_DEPTH      = 4,
    parameter int MAX_NET_BURST = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] net_TDATA,
    input  logic             net_TVALID,
    output logic             net_TREADY,
    input  logic [WIDTH-1:0] lb_TDATA,
    input  logic             lb_TVALID,
    output logic             lb_TREADY,
    output logic [WIDTH-1:0] tx_TDATA,
    output logic             tx_TVALID,
    input  logic             tx_TREADY,
    output logic [31:0]      retry_cnt,
    output logic [31:0]      rst_drop_cnt
);
    localparam int CW = $clog2(LB_DEPTH) + 1;
    localparam int BW = $clog2(MAX_NET_BURST + 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [WIDTH-1:0] fifo_rd_data;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_nonempty;
    logic             lb_hs;
    logic             lb_push;
    logic             lb_drop;
    logic             load;
    logic             lb_first;
    logic             pick_lb;
    logic             pick_net;
    logic [BW-1:0]    burst;
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;

    assign fifo_nonempty = ~fifo_empty;
    assign lb_TREADY     = (fifo_count < CW'(LB_DEPTH)) & ~flush;
    assign lb_hs         = lb_TVALID & lb_TREADY;
    assign lb_push       = lb_hs & ~lb_TDATA[HDR_RST_BIT];
    assign lb_drop       = lb_hs &  lb_TDATA[HDR_RST_BIT];

    // Loopback wins when the network is idle or has used up its burst allowance.
    assign load       = ~vld_p1 | tx_TREADY;
    assign lb_first   = fifo_nonempty & (~net_TVALID | (burst == BW'(MAX_NET_BURST)));
    assign pick_lb    = load & lb_first & ~flush;
    assign pick_net   = load & net_TVALID & ~lb_first & ~flush;
    assign net_TREADY = load & ~lb_first & ~flush;

    sync_fifo_lb #(
        .WIDTH (WIDTH),
        .DEPTH (LB_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (lb_push),
        .wr_data (lb_TDATA),
        .rd_en   (pick_lb),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // Stage p1: output register into the dispatcher rx port.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (load) begin
            vld_p1 <= pick_lb | pick_net;
            if (pick_lb) begin
                data_p1 <= fifo_rd_data;
            end else if (pick_net) begin
                data_p1 <= net_TDATA;
            end
        end
    end

    assign tx_TDATA  = data_p1;
    assign tx_TVALID = vld_p1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            burst <= '0;
        end else if (pick_lb) begin
            burst <= '0;
        end else if (pick_net) begin
            burst <= fifo_nonempty ? burst + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt    <= '0;
            rst_drop_cnt <= '0;
        end else begin
            if (pick_lb) retry_cnt    <= sat_inc(retry_cnt);
            if (lb_drop) rst_drop_cnt <= sat_inc(rst_drop_cnt);
        end
    end
endmodule

// File: tb/tb_omni_merger.sv
// Directed bench for omni_merger: reset, network streaming, starvation bound,
// reset-header drop, full FIFO with backpressure, flush and mid-transfer reset.
module tb_omni_merger;
    localparam int W = 600;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [W-1:0] net_TDATA;
    logic         net_TVALID;
    logic         net_TREADY;
    logic [W-1:0] lb_TDATA;
    logic         lb_TVALID;
    logic         lb_TREADY;
    logic [W-1:0] tx_TDATA;
    logic         tx_TVALID;
    logic         tx_TREADY;
    logic [31:0]  retry_cnt;
    logic [31:0]  rst_drop_cnt;

    int errors = 0;
    int checks = 0;

    omni_merger #(.WIDTH(W), .LB_DEPTH(4), .MAX_NET_BURST(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .net_TDATA    (net_TDATA),
        .net_TVALID   (net_TVALID),
        .net_TREADY   (net_TREADY),
        .lb_TDATA     (lb_TDATA),
        .lb_TVALID    (lb_TVALID),
        .lb_TREADY    (lb_TREADY),
        .tx_TDATA     (tx_TDATA),
        .tx_TVALID    (tx_TVALID),
        .tx_TREADY    (tx_TREADY),
        .retry_cnt    (retry_cnt),
        .rst_drop_cnt (rst_drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [31:0] pl, input logic [31:0] hdr);
        return {88'd0, 448'd0, pl, hdr};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; tx_TREADY = 1'b1;
        net_TVALID = 1'b0; net_TDATA = '0; lb_TVALID = 1'b0; lb_TDATA = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #1;
        checks++; if (tx_TVALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_TVALID); end
        checks++; if (tx_TDATA !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", tx_TDATA); end
        checks++; if (retry_cnt !== 32'd0) begin errors++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
        checks++; if (rst_drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", rst_drop_cnt); end
        checks++; if (lb_TREADY !== 1'b1) begin errors++; $display("FAIL reset_lb_ready: got %b expected 1", lb_TREADY); end
        checks++; if (net_TREADY !== 1'b1) begin errors++; $display("FAIL reset_net_ready: got %b expected 1", net_TREADY); end
    endtask

    task automatic test_net_only;
        tx_TREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            net_TDATA = mk(i, 32'h4); net_TVALID = 1'b1; #1;
            checks++; if (net_TREADY !== 1'b1) begin errors++; $display("FAIL net_ready[%0d]: got %b expected 1", i, net_TREADY); end
            tick;
            checks++; if (tx_TVALID !== 1'b1 || tx_TDATA !== mk(i, 32'h4)) begin
                errors++; $display("FAIL net_word[%0d]: got v=%b %h expected v=1 %h", i, tx_TVALID, tx_TDATA, mk(i, 32'h4));
            end
        end
        net_TVALID = 1'b0;
        tick;
        checks++; if (tx_TVALID !== 1'b0) begin errors++; $display("FAIL net_idle: got %b expected 0", tx_TVALID); end
        checks++; if (retry_cnt !== 32'd0) begin errors++; $display("FAIL net_retry: got %0d expected 0", retry_cnt); end
    endtask

    task automatic test_starvation;
        tx_TREADY = 1'b1;
        lb_TDATA = mk(32'hAB, 32'h8); lb_TVALID = 1'b1;
        net_TDATA = mk(100, 32'h4); net_TVALID = 1'b1;
        tick;
        lb_TVALID = 1'b0;
        checks++; if (tx_TDATA !== mk(100, 32'h4)) begin errors++; $display("FAIL starve_first: got %h expected %h", tx_TDATA, mk(100, 32'h4)); end
        for (int k = 1; k <= 8; k++) begin
            net_TDATA = mk(100 + k, 32'h4);
            tick;
            checks++; if (tx_TVALID !== 1'b1 || tx_TDATA !== mk(100 + k, 32'h4)) begin
                errors++; $display("FAIL starve_net[%0d]: got %h expected %h", k, tx_TDATA, mk(100 + k, 32'h4));
            end
        end
        net_TDATA = mk(109, 32'h4); #1;
        checks++; if (net_TREADY !== 1'b0) begin errors++; $display("FAIL starve_net_ready: got %b expected 0", net_TREADY); end
        tick;
        checks++; if (tx_TVALID !== 1'b1 || tx_TDATA !== mk(32'hAB, 32'h8)) begin
            errors++; $display("FAIL starve_lb_word: got %h expected %h", tx_TDATA, mk(32'hAB, 32'h8));
        end
        checks++; if (retry_cnt !== 32'd1) begin errors++; $display("FAIL starve_retry: got %0d expected 1", retry_cnt); end
        tick;
        checks++; if (tx_TDATA !== mk(109, 32'h4)) begin errors++; $display("FAIL starve_resume: got %h expected %h", tx_TDATA, mk(109, 32'h4)); end
        net_TVALID = 1'b0;
        tick;
        checks++; if (tx_TVALID !== 1'b0) begin errors++; $display("FAIL starve_idle: got %b expected 0", tx_TVALID); end
    endtask

    task automatic test_rst_drop;
        lb_TDATA = mk(0, 32'h11); lb_TVALID = 1'b1; #1;
        checks++; if (lb_TREADY !== 1'b1) begin errors++; $display("FAIL drop_lb_ready: got %b expected 1", lb_TREADY); end
        tick;
        lb_TVALID = 1'b0;
        checks++; if (rst_drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_cnt: got %0d expected 1", rst_drop_cnt); end
        checks++; if (net_TREADY !== 1'b1) begin errors++; $display("FAIL drop_fifo_empty: net_TREADY got %b expected 1", net_TREADY); end
        tick;
        checks++; if (tx_TVALID !== 1'b0) begin errors++; $display("FAIL drop_not_forwarded: got %b expected 0", tx_TVALID); end
        checks++; if (retry_cnt !== 32'd1) begin errors++; $display("FAIL drop_retry: got %0d expected 1", retry_cnt); end
    endtask

    task automatic test_full_backpressure;
        tx_TREADY = 1'b0;
        net_TDATA = mk(200, 32'h4); net_TVALID = 1'b1;
        tick;
        net_TVALID = 1'b0;
        checks++; if (tx_TVALID !== 1'b1 || tx_TDATA !== mk(200, 32'h4)) begin
            errors++; $display("FAIL bp_hold_load: got v=%b %h expected v=1 %h", tx_TVALID, tx_TDATA, mk(200, 32'h4));
        end
        for (int j = 0; j < 4; j++) begin
            lb_TDATA = mk(300 + j, 32'h8); lb_TVALID = 1'b1; #1;
            checks++; if (lb_TREADY !== 1'b1) begin errors++; $display("FAIL bp_push_ready[%0d]: got %b expected 1", j, lb_TREADY); end
            tick;
        end
        lb_TDATA = mk(304, 32'h8); #1;
        checks++; if (lb_TREADY !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", lb_TREADY); end
        checks++; if (tx_TVALID !== 1'b1 || tx_TDATA !== mk(200, 32'h4)) begin
            errors++; $display("FAIL bp_stable: got v=%b %h expected v=1 %h", tx_TVALID, tx_TDATA, mk(200, 32'h4));
        end
        lb_TVALID = 1'b0;
        tx_TREADY = 1'b1; #1;
        checks++; if (lb_TREADY !== 1'b0) begin errors++; $display("FAIL bp_full_pop_ready: got %b expected 0", lb_TREADY); end
        for (int j = 0; j < 4; j++) begin
            tick;
            checks++; if (tx_TVALID !== 1'b1 || tx_TDATA !== mk(300 + j, 32'h8)) begin
                errors++; $display("FAIL bp_drain[%0d]: got %h expected %h", j, tx_TDATA, mk(300 + j, 32'h8));
            end
        end
        tick;
        checks++; if (tx_TVALID !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", tx_TVALID); end
        checks++; if (retry_cnt !== 32'd5) begin errors++; $display("FAIL bp_retry: got %0d expected 5", retry_cnt); end
    endtask

    task automatic test_flush;
        tx_TREADY = 1'b0;
        net_TDATA = mk(400, 32'h4); net_TVALID = 1'b1;
        tick;
        net_TVALID = 1'b0;
        for (int j = 0; j < 3; j++) begin
            lb_TDATA = mk(500 + j, 32'h8); lb_TVALID = 1'b1;
            tick;
        end
        checks++; if (tx_TVALID !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", tx_TVALID); end
        flush = 1'b1; lb_TDATA = mk(510, 32'h8); #1;
        checks++; if (lb_TREADY !== 1'b0) begin errors++; $display("FAIL flush_lb_ready: got %b expected 0", lb_TREADY); end
        tick;
        flush = 1'b0; lb_TVALID = 1'b0;
        checks++; if (tx_TVALID !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", tx_TVALID); end
        checks++; if (tx_TDATA !== '0) begin errors++; $display("FAIL flush_data: got %h expected 0", tx_TDATA); end
        checks++; if (retry_cnt !== 32'd5) begin errors++; $display("FAIL flush_retry: got %0d expected 5", retry_cnt); end
        checks++; if (rst_drop_cnt !== 32'd1) begin errors++; $display("FAIL flush_drop: got %0d expected 1", rst_drop_cnt); end
        #1;
        checks++; if (net_TREADY !== 1'b1) begin errors++; $display("FAIL flush_fifo_empty: net_TREADY got %b expected 1", net_TREADY); end
        tick;
        checks++; if (tx_TVALID !== 1'b0) begin errors++; $display("FAIL flush_no_output: got %b expected 0", tx_TVALID); end
        tx_TREADY = 1'b1;
    endtask

    task automatic test_reset_mid;
        tx_TREADY = 1'b0;
        net_TDATA = mk(600, 32'h4); net_TVALID = 1'b1;
        tick;
        net_TVALID = 1'b0;
        lb_TDATA = mk(700, 32'h8); lb_TVALID = 1'b1;
        tick;
        lb_TVALID = 1'b0;
        checks++; if (tx_TVALID !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", tx_TVALID); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (tx_TVALID !== 1'b0 || tx_TDATA !== '0) begin
            errors++; $display("FAIL rmid_tx: got v=%b %h expected v=0 0", tx_TVALID, tx_TDATA);
        end
        checks++; if (retry_cnt !== 32'd0 || rst_drop_cnt !== 32'd0) begin
            errors++; $display("FAIL rmid_counters: got %0d/%0d expected 0/0", retry_cnt, rst_drop_cnt);
        end
        #1;
        checks++; if (net_TREADY !== 1'b1) begin errors++; $display("FAIL rmid_fifo_empty: net_TREADY got %b expected 1", net_TREADY); end
        tx_TREADY = 1'b1;
    endtask

    initial begin
        test_reset;
        test_net_only;
        test_starvation;
        test_rst_drop;
        test_full_backpressure;
        test_flush;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
